// File: rtl/load_store_unit.sv
// load_store_unit: word-wide data-memory initiator for the MEM stage.
// Accepts one load/store at a time. Sub-word stores use read-modify-write.
// Load data is lane-selected and then sign- or zero-extended.
module load_store_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    STORE    = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state_reg, state_next;

  // The load/store direction is carried by the state path, so it is not kept separately.
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_reg;
  logic [31:0] rdata_reg;
  logic        fault_reg;

  logic        req_fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Decode illegal funct3, unsigned stores and misaligned halfword/word accesses.
  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = (req_addr[1:0] != 2'b00);
      3'b100:  req_fault = req_we;
      3'b101:  req_fault = req_we | req_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // State register. The reset is asynchronous so that mem_WE drops immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. In IDLE the priority order is fault, then load, then word store, then sub-word store.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_fault)                 state_next = RESP;
          else if (!req_we)              state_next = LOAD;
          else if (req_funct3 == 3'b010) state_next = STORE;
          else                           state_next = RMW_READ;
        end
      end
      LOAD:     state_next = RESP;
      RMW_READ: state_next = STORE;
      STORE:    state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Select the load lane using little-endian order, then extend it according to funct3.
  always_comb begin
    ld_byte   = mem_RD[{addr_reg[1:0], 3'b000} +: 8];
    ld_half   = addr_reg[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_data = mem_RD;
    case (funct3_reg)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_RD;
    endcase
  end

  // Build the merged word one byte lane at a time.
  // SB replaces the single addressed byte. SH replaces the addressed half.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = funct3_reg[0] ? (addr_reg[1] == 1'(gi / 2))
                                      : (addr_reg[1:0] == 2'(gi));
      assign lane_src = funct3_reg[0] ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[7:0];
      assign merged[8*gi +: 8] = lane_hit ? lane_src : mem_RD[8*gi +: 8];
    end
  endgenerate

  // Latch the request at accept and capture read data.
  // rsp_rdata only changes on the way into RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      funct3_reg <= 3'b000;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      merge_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
      fault_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            fault_reg  <= req_fault;
            if (req_fault) rdata_reg <= 32'h0;
          end
        end
        LOAD:     rdata_reg <= load_data;
        RMW_READ: merge_reg <= merged;
        STORE:    rdata_reg <= 32'h0;
        default:  ;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_fault = fault_reg & rsp_valid;
  assign rsp_rdata = rdata_reg;
  assign mem_A     = {addr_reg[31:2], 2'b00};
  assign mem_WE    = (state_reg == STORE);
  assign mem_WD    = (funct3_reg == 3'b010) ? wdata_reg : merge_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed test of load_store_unit.
// The bench also models a small word-wide data memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] dmem [0:63] = '{default: 32'h0};
  assign mem_RD = dmem[mem_A[7:2]];
  always @(posedge CLK) if (mem_WE) dmem[mem_A[7:2]] <= mem_WD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    logic [31:0] exp_word;   // expected contents of word 0x10 after the transaction
  } vec_t;

  vec_t vt [0:19];
  vec_t bb [0:3];
  int   bb_lat [0:3];

  initial begin
    int lat;
    logic [31:0] rd;
    logic ft, we_seen, busy_ready, got, seen;
    int acc, rsp;
    int acc_cyc [0:3];
    logic will_acc;

    //            we    f3      addr    wdata         rdata          flt  lat word
    vt[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h00000000, 1'b0, 3, 32'hDEADA5EF};
    vt[3]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 32'hDEADA5EF};
    vt[4]  = '{1'b0, 3'b100, 32'h11, 32'h0,        32'h000000A5, 1'b0, 2, 32'hDEADA5EF};
    vt[5]  = '{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h00000000, 1'b0, 3, 32'h1234A5EF};
    vt[6]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0, 2, 32'h1234A5EF};
    vt[7]  = '{1'b1, 3'b001, 32'h12, 32'h00008000, 32'h00000000, 1'b0, 3, 32'h8000A5EF};
    vt[8]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8000, 1'b0, 2, 32'h8000A5EF};
    vt[9]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008000, 1'b0, 2, 32'h8000A5EF};
    vt[10] = '{1'b0, 3'b010, 32'h13, 32'h0,        32'h00000000, 1'b1, 1, 32'h8000A5EF};
    vt[11] = '{1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 32'h8000A5EF};
    vt[12] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1, 1, 32'h8000A5EF};
    vt[13] = '{1'b1, 3'b100, 32'h10, 32'h000000FF, 32'h00000000, 1'b1, 1, 32'h8000A5EF};
    vt[14] = '{1'b1, 3'b010, 32'h12, 32'h55555555, 32'h00000000, 1'b1, 1, 32'h8000A5EF};
    vt[15] = '{1'b1, 3'b000, 32'h13, 32'h12345677, 32'h00000000, 1'b0, 3, 32'h7700A5EF};
    vt[16] = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h00000077, 1'b0, 2, 32'h7700A5EF};
    vt[17] = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 32'h7700A5EF};
    vt[18] = '{1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFA5EF, 1'b0, 2, 32'h7700A5EF};
    vt[19] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h7700A5EF, 1'b0, 2, 32'h7700A5EF};

    // Back-to-back sequence on word 0x30. The exp_word field is unused here.
    bb[0] = '{1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 32'h0};
    bb[1] = '{1'b0, 3'b010, 32'h30, 32'h0,        32'hCAFEF00D, 1'b0, 2, 32'h0};
    bb[2] = '{1'b1, 3'b000, 32'h31, 32'h00000011, 32'h00000000, 1'b0, 3, 32'h0};
    bb[3] = '{1'b0, 3'b000, 32'h31, 32'h0,        32'h00000011, 1'b0, 2, 32'h0};
    bb_lat[0] = 2; bb_lat[1] = 2; bb_lat[2] = 3; bb_lat[3] = 2;

    // Check the state of every output while reset is held.
    repeat (2) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'h0);
    check("rst_mem_A", mem_A, 32'h0);
    check("rst_mem_WD", mem_WD, 32'h0);
    check("rst_mem_WE", 32'(mem_WE), 32'h0);
    $display("[TB] reset: ready=%0b valid=%0b rdata=0x%08h", req_ready, rsp_valid, rsp_rdata);
    RST = 1'b0;

    // Apply the directed vectors, one request at a time.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("v%0d_ready_idle", i), 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = vt[i].we; req_funct3 = vt[i].f3;
      req_addr = vt[i].addr; req_wdata = vt[i].wdata;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      lat = 0; rd = 32'hX; ft = 1'bX; we_seen = 1'b0; busy_ready = 1'b0; got = 1'b0;
      for (int c = 1; c <= 6 && !got; c++) begin
        @(negedge CLK);
        if (mem_WE) we_seen = 1'b1;
        if (req_ready) busy_ready = 1'b1;
        if (rsp_valid) begin got = 1'b1; lat = c; rd = rsp_rdata; ft = rsp_fault; end
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("v%0d_fault", i), 32'(ft), 32'(vt[i].exp_fault));
      check($sformatf("v%0d_busy_ready", i), 32'(busy_ready), 32'h0);
      check($sformatf("v%0d_mem_we", i), 32'(we_seen), 32'(vt[i].we & ~vt[i].exp_fault));
      check($sformatf("v%0d_word10", i), dmem[4], vt[i].exp_word);
      @(negedge CLK);
      check($sformatf("v%0d_rsp_one_cycle", i), 32'(rsp_valid), 32'h0);
      $display("[TB] v%0d we=%0b f3=%03b addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h fault=%0b word10=0x%08h",
               i, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, rd, ft, dmem[4]);
    end

    // Back-to-back traffic with req_valid held high. Each request must be accepted once, and responses must come back in order.
    acc = 0; rsp = 0;
    @(negedge CLK);
    for (int c = 0; c < 40 && rsp < 4; c++) begin
      if (rsp_valid) begin
        check($sformatf("bb%0d_rdata", rsp), rsp_rdata, bb[rsp].exp_rdata);
        check($sformatf("bb%0d_fault", rsp), 32'(rsp_fault), 32'h0);
        check($sformatf("bb%0d_latency", rsp), 32'(c - acc_cyc[rsp]), 32'(bb_lat[rsp]));
        check($sformatf("bb%0d_ready_in_resp", rsp), 32'(req_ready), 32'h0);
        $display("[TB] bb%0d addr=0x%08h -> rdata=0x%08h lat=%0d", rsp, bb[rsp].addr, rsp_rdata, c - acc_cyc[rsp]);
        rsp++;
      end
      if (acc < 4) begin
        req_valid = 1'b1; req_we = bb[acc].we; req_funct3 = bb[acc].f3;
        req_addr = bb[acc].addr; req_wdata = bb[acc].wdata;
      end else begin
        req_valid = 1'b0;
      end
      will_acc = req_ready & req_valid;
      @(posedge CLK);
      if (will_acc) begin acc_cyc[acc] = c; acc++; end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    check("bb_responses", 32'(rsp), 32'h4);
    check("bb_accepts", 32'(acc), 32'h4);
    seen = 1'b0;
    repeat (6) begin @(negedge CLK); if (rsp_valid) seen = 1'b1; end
    check("bb_no_extra_rsp", 32'(seen), 32'h0);
    check("bb_word30", dmem[12], 32'hCAFE110D);

    // Assert reset while a word store is in STORE. The write must be dropped, and no response may be issued.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h11112222;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    check("rstmid_we_before", 32'(mem_WE), 32'h1);
    RST = 1'b1;
    #1;
    check("rstmid_we_drop", 32'(mem_WE), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge CLK); if (rsp_valid) seen = 1'b1; end
    check("rstmid_no_rsp", 32'(seen), 32'h0);
    check("rstmid_word20", dmem[8], 32'h0);
    check("rstmid_ready", 32'(req_ready), 32'h1);
    $display("[TB] reset mid-store: word20=0x%08h ready=%0b rsp_seen=%0b", dmem[8], req_ready, seen);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
